// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Default digit limits match a 99:59 display range.
package bcd_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam bcd_t BCD_ZERO       = 4'd0;
    localparam bcd_t UNITS_MAX_C    = 4'd9;
    localparam bcd_t SEC_TENS_MAX_C = 4'd5;
    localparam bcd_t MIN_TENS_MAX_C = 4'd9;

    function automatic bcd_t bcd_clamp(input bcd_t v, input bcd_t max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MAX and raises borrow_out so the
// next more-significant digit steps in the same cycle.
module bcd_down_digit
    import bcd_timer_pkg::*;
#(
    parameter bcd_t MAX = UNITS_MAX_C
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic borrow_in,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t digit,
    output logic borrow_out
);

    bcd_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (en && borrow_in) begin
            digit_d = (digit_q == BCD_ZERO) ? MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = borrow_in && (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with one-cycle expiry pulse and latched alarm.
// Build option AUTO_RELOAD_EN: on expiry reload the shadow preset and keep running.
//
// state   | meaning
// IDLE    | loaded or acknowledged, waiting for start
// RUN     | decrementing once per tick
// PAUSE   | count frozen, start resumes
// EXPIRED | reached 00:00, holds until ack or load
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter bcd_t SEC_TENS_MAX = SEC_TENS_MAX_C,
    parameter bcd_t UNITS_MAX    = UNITS_MAX_C,
    parameter bcd_t MIN_TENS_MAX = MIN_TENS_MAX_C
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic load,
    input  logic start,
    input  logic pause,
    input  logic ack,
    input  bcd_t preset_min1,
    input  bcd_t preset_min0,
    input  bcd_t preset_sec1,
    input  bcd_t preset_sec0,
    output bcd_t min1,
    output bcd_t min0,
    output bcd_t sec1,
    output bcd_t sec0,
    output logic running,
    output logic expired,
    output logic alarm
);

    state_t state_q, state_d;
    logic   running_q, running_d;
    logic   expired_q, expired_d;
    logic   alarm_q, alarm_d;
    logic [15:0] shadow_q, shadow_d;

    logic dec, ld, reload;
    logic b_sec0, b_sec1, b_min0, borrow_unused;
    logic [15:0] preset_clamped, load_val, count;
    logic cnt_zero, cnt_one;

    assign preset_clamped = {bcd_clamp(preset_min1, MIN_TENS_MAX),
                             bcd_clamp(preset_min0, UNITS_MAX),
                             bcd_clamp(preset_sec1, SEC_TENS_MAX),
                             bcd_clamp(preset_sec0, UNITS_MAX)};
    assign load_val = reload ? shadow_q : preset_clamped;
    assign count    = {min1, min0, sec1, sec0};
    assign cnt_zero = (count == {BCD_ZERO, BCD_ZERO, BCD_ZERO, BCD_ZERO});
    assign cnt_one  = (count == {BCD_ZERO, BCD_ZERO, BCD_ZERO, 4'd1});

    // Priority: ack > load > pause > start > tick; load in RUN is not a command.
    always_comb begin
        state_d   = state_q;
        alarm_d   = alarm_q;
        expired_d = 1'b0;
        shadow_d  = shadow_q;
        dec       = 1'b0;
        ld        = 1'b0;
        reload    = 1'b0;
        if (ack) begin
            alarm_d = 1'b0;
            if (state_q == EXPIRED) state_d = IDLE;
        end else if (load && state_q != RUN) begin
            ld       = 1'b1;
            shadow_d = preset_clamped;
            state_d  = IDLE;
            alarm_d  = 1'b0;
        end else if (pause) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start) begin
            if ((state_q == IDLE || state_q == PAUSE) && !cnt_zero) state_d = RUN;
        end else if (tick && state_q == RUN) begin
            if (cnt_one) begin
                expired_d = 1'b1;
                alarm_d   = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (shadow_q != 16'h0000) begin
                    reload = 1'b1;
                end else begin
                    dec     = 1'b1;
                    state_d = EXPIRED;
                end
`else
                dec     = 1'b1;
                state_d = EXPIRED;
`endif
            end else begin
                dec = 1'b1;
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
            shadow_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            expired_q <= expired_d;
            alarm_q   <= alarm_d;
            shadow_q  <= shadow_d;
        end
    end

    bcd_down_digit #(.MAX(UNITS_MAX)) u_sec0 (
        .clk(clk), .reset(reset), .en(dec), .borrow_in(1'b1),
        .load(ld | reload), .load_val(load_val[3:0]),
        .digit(sec0), .borrow_out(b_sec0)
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec1 (
        .clk(clk), .reset(reset), .en(dec), .borrow_in(b_sec0),
        .load(ld | reload), .load_val(load_val[7:4]),
        .digit(sec1), .borrow_out(b_sec1)
    );

    bcd_down_digit #(.MAX(UNITS_MAX)) u_min0 (
        .clk(clk), .reset(reset), .en(dec), .borrow_in(b_sec1),
        .load(ld | reload), .load_val(load_val[11:8]),
        .digit(min0), .borrow_out(b_min0)
    );

    // Minutes tens never borrows out: the count stops at 00:00.
    bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min1 (
        .clk(clk), .reset(reset), .en(dec), .borrow_in(b_min0),
        .load(ld | reload), .load_val(load_val[15:12]),
        .digit(min1), .borrow_out(borrow_unused)
    );

    assign running = running_q;
    assign expired = expired_q;
    assign alarm   = alarm_q;

endmodule
